// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, decode NOP encoding, fetch FSM states.
package pipe_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0020;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge/response bus between fetch and imem.
interface fetch_stage_if;
  import pipe_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcp1, valid} holding buffer for a response that found the output register full.
module fetch_skid_buf
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            RST_N,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pcp1_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pcp1,
  output logic            valid
);
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pcp1  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pcp1  <= pcp1_in;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds the F/D register.
// Optional one-entry skid buffer enabled by defining FETCH_SKID_BUF_EN.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              StallF,
  input  logic              BranchE,
  input  logic [XLEN-1:0]   BranchTargetE,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   IMRD,
  output logic [XLEN-1:0]   PCp1F,
  output logic              FlushD
);
  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n, pc_p1;
  logic [XLEN-1:0] or_instr, or_instr_n;
  logic [XLEN-1:0] or_pcp1, or_pcp1_n;
  logic            or_valid, or_valid_n;
  logic            accepted, or_consumed, or_space;

`ifdef FETCH_SKID_BUF_EN
  logic            sk_load, sk_unload, sk_clear, sk_valid;
  logic [XLEN-1:0] sk_instr, sk_pcp1;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .RST_N    (RST_N),
    .load     (sk_load),
    .unload   (sk_unload),
    .clear    (sk_clear),
    .instr_in (imem.imem_rdata),
    .pcp1_in  (pc_p1),
    .instr    (sk_instr),
    .pcp1     (sk_pcp1),
    .valid    (sk_valid)
  );
`endif

  assign pc_p1          = pc_inc(pc);
  assign imem.imem_req  = RST_N & (state == ISSUE);
  assign imem.imem_addr = pc;
  assign accepted       = imem.imem_req & imem.imem_ack;
  assign or_consumed    = or_valid & ~StallF & ~BranchE;
  assign or_space       = ~or_valid | or_consumed;

  assign IMRD   = or_valid ? or_instr : NOP_INSTR;
  assign PCp1F  = or_pcp1;
  assign FlushD = ~or_valid | BranchE;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ISSUE;
      pc       <= RESET_PC;
      or_instr <= NOP_INSTR;
      or_pcp1  <= pc_inc(RESET_PC);
      or_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      or_instr <= or_instr_n;
      or_pcp1  <= or_pcp1_n;
      or_valid <= or_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    or_instr_n = or_instr;
    or_pcp1_n  = or_pcp1;
    or_valid_n = or_valid & ~or_consumed;
`ifdef FETCH_SKID_BUF_EN
    sk_load    = 1'b0;
    sk_unload  = 1'b0;
    sk_clear   = 1'b0;
`endif
    if (BranchE) begin
      // Redirect: go to DRAIN only if a response is still owed after this edge.
      pc_n       = BranchTargetE;
      or_valid_n = 1'b0;
`ifdef FETCH_SKID_BUF_EN
      sk_clear   = 1'b1;
`endif
      case (state)
        ISSUE:   state_n = accepted ? DRAIN : ISSUE;
        WAIT:    state_n = imem.imem_rvalid ? ISSUE : DRAIN;
        DRAIN:   state_n = imem.imem_rvalid ? ISSUE : DRAIN;
        default: state_n = ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: if (accepted) state_n = WAIT;
        WAIT: if (imem.imem_rvalid) begin
          if (or_space) begin
            or_instr_n = imem.imem_rdata;
            or_pcp1_n  = pc_p1;
            or_valid_n = 1'b1;
            pc_n       = pc_p1;
            state_n    = ISSUE;
          end else begin
`ifdef FETCH_SKID_BUF_EN
            sk_load = 1'b1;
            state_n = HOLD;
`else
            state_n = ISSUE;
`endif
          end
        end
        DRAIN: if (imem.imem_rvalid) state_n = ISSUE;
`ifdef FETCH_SKID_BUF_EN
        HOLD: if (or_consumed && sk_valid) begin
          or_instr_n = sk_instr;
          or_pcp1_n  = sk_pcp1;
          or_valid_n = 1'b1;
          pc_n       = pc_p1;
          sk_unload  = 1'b1;
          state_n    = ISSUE;
        end
`endif
        default: state_n = ISSUE;
      endcase
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage driving the decode pipeline register: owns the PC, issues word-addressed requests to instruction memory over a request/acknowledge/response handshake, and presents `IMRD`/`PCp1F` plus a flush strobe to the F/D register. Honors decode stalls and execute-stage branch redirects. It writes the interface that the decode register reads, supplying the NOP instruction whenever it has nothing valid.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  clock, all state on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `StallF`  in  1  decode register holding (its EN=1); fetch output not consumed this edge.
- `BranchE`  in  1  redirect request from execute.
- `BranchTargetE`  in  32  redirect PC.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address (= PC).
- `imem_ack`  in  1  request accepted this edge (`imem_req & imem_ack`).
- `imem_rvalid`  in  1  response valid, exactly one per accepted request, ≥1 cycle after acceptance.
- `imem_rdata`  in  32  response instruction.
- `IMRD`  out  32  fetched instruction to decode register.
- `PCp1F`  out  32  PC+1 of `IMRD`.
- `FlushD`  out  1  drives decode register CLR.

## Operation
- Output register OR = {`IMRD`, `PCp1F`, `or_valid`}. OR consumed at an edge where `or_valid & !StallF & !BranchE`.
- `FlushD` = `!or_valid | BranchE` (combinational), so decode loads NOP when fetch is empty or on redirect.
- At most one outstanding memory request.
- FSM states:
  - ISSUE: `imem_req`=1, `imem_addr`=PC. On ack → WAIT.
  - WAIT: on `imem_rvalid`: if OR empty or consumed this edge → load OR with {rdata, PC+1}, PC←PC+1, → ISSUE. Otherwise → conflict handling (see Configuration).
  - DRAIN: response for a squashed request pending; on `imem_rvalid` discard data, → ISSUE.
  - HOLD (skid build only): skid entry full; when OR consumed, move skid→OR, PC←PC+1, → ISSUE.
- Redirect (`BranchE`=1 at an edge, priority over everything): PC←`BranchTargetE`, `or_valid`←0, skid cleared. Next state: ISSUE if no request outstanding after this edge (ISSUE without ack, or WAIT with rvalid this edge, or HOLD); DRAIN if a request is outstanding (ISSUE with ack, WAIT without rvalid). `imem_addr` may change while `imem_req`=1 and not yet acked.
- PC+1 is 32-bit, wraps: 32'hFFFF_FFFF+1 = 0.

## Timing
- Reset values: PC=`RESET_PC`, state=ISSUE, `or_valid`=0, `IMRD`=32'h0000_0020, `PCp1F`=`RESET_PC`+1, `FlushD`=1, `imem_req`=0 while `RST_N`=0, 1 from first cycle after release.
- Reset mid-operation: all state cleared asynchronously; instruction memory shares `RST_N`, so no stale response arrives after release.
- Latency: memory latency L cycles ⇒ first `or_valid` at edge 1+L after release with ack on first cycle; steady-state throughput one instruction per L+1 cycles.
- `IMRD`/`PCp1F` stable while `or_valid & StallF`.

## Configuration
- `FETCH_SKID_BUF_EN` defined: one-entry skid buffer. Response arriving while OR full and not consumed is captured into skid, → HOLD; no refetch.
- Undefined: that response is discarded, PC unchanged, → ISSUE (refetch same address). No HOLD state, no skid storage.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR` = 32'h0000_0020, `fetch_state_t` enum (ISSUE, WAIT, DRAIN, HOLD), `XLEN` = 32.
- Sub-module `fetch_skid_buf`: one-entry {instr, pcp1, valid} buffer with load/unload/clear; instantiated only under `FETCH_SKID_BUF_EN`.

## Test plan
- Reset release, L=1, ack always, no stall → `IMRD` sequence mem[0],mem[1],mem[2] at one per 2 cycles, `PCp1F`=1,2,3, `FlushD`=0 only while `or_valid`.
- `StallF` held 5 cycles with OR full and response arriving → `IMRD`/`PCp1F` unchanged; skid build: no second request to same address; non-skid build: `imem_addr` re-issued to same PC.
- `BranchE`=1 target 32'h40 while in WAIT → `FlushD`=1 that cycle, in-flight rdata discarded (DRAIN), next `imem_addr`=32'h40, next `IMRD`=mem[0x40], `PCp1F`=32'h41.
- `BranchE` and `StallF` same cycle with OR full → redirect wins: `or_valid`=0, `FlushD`=1, PC=target.
- PC at 32'hFFFF_FFFF → `PCp1F`=0, next `imem_addr`=0.
- `RST_N` low during WAIT → outputs immediately at reset values; after release first `imem_addr`=`RESET_PC`.
